// File: rtl/register_display_scanner_pkg.sv
// rtl/register_display_scanner_pkg.sv - seven-segment encodings and shared types for the register scanner
package register_display_scanner_pkg;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_INC,
        STEP_DEC
    } step_e;

    // Active-low segments, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/register_display_scanner_if.sv
// rtl/register_display_scanner_if.sv - register file display port (select out, data back)
interface register_display_scanner_if;
    logic [4:0]  displaySelect;
    logic [31:0] displayData;

    modport master (output displaySelect, input displayData);
    modport slave  (input displaySelect, output displayData);
endinterface

// File: rtl/register_display_scanner_button_debouncer.sv
// rtl/register_display_scanner_button_debouncer.sv - 2-FF sync, stable-count debounce, rising-edge pulse
module register_display_scanner_button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only advances on consecutive mismatching cycles; a matching cycle restarts it.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    assign pulse_o = level_q & ~level_dly_q;

endmodule

// File: rtl/register_display_scanner.sv
// rtl/register_display_scanner.sv - button/auto stepping of the register index with hex display of its value
module register_display_scanner
    import register_display_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned AUTO_CYCLES     = 50_000_000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              btn_next,
    input  logic                              btn_prev,
    input  logic                              sw_auto,
    register_display_scanner_if.master        rf,
    output logic [6:0]                        hex0,
    output logic [6:0]                        hex1,
    output logic [6:0]                        hex2,
    output logic [6:0]                        hex3,
    output logic [6:0]                        hex4,
    output logic [6:0]                        hex5,
    output logic [6:0]                        hex6,
    output logic [6:0]                        hex7
);

    localparam int unsigned TMR_W = $clog2(AUTO_CYCLES + 1);

    logic             next_p, prev_p;
    logic             sw_s1_q, sw_s2_q;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [4:0]       idx_q, idx_d;
    logic [31:0]      data_q;
    step_e            step;

    register_display_scanner_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_next),
        .pulse_o (next_p)
    );

    register_display_scanner_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_prev),
        .pulse_o (prev_p)
    );

    // Any button pulse wins over the auto tick and restarts the auto interval.
    always_comb begin
        tmr_d = '0;
        step  = STEP_NONE;
        if (next_p && !prev_p) begin
            step = STEP_INC;
        end else if (prev_p && !next_p) begin
            step = STEP_DEC;
        end
        if (!(next_p || prev_p) && sw_s2_q) begin
            if (tmr_q == TMR_W'(AUTO_CYCLES - 1)) begin
                step = STEP_INC;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
        case (step)
            STEP_INC: idx_d = idx_q + 5'd1;
            STEP_DEC: idx_d = idx_q - 5'd1;
            default:  idx_d = idx_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q <= 1'b0;
            sw_s2_q <= 1'b0;
            tmr_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            sw_s1_q <= sw_auto;
            sw_s2_q <= sw_s1_q;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            data_q  <= rf.displayData;
        end
    end

    assign rf.displaySelect = idx_q;

    assign hex0 = hex_to_seg(data_q[3:0]);
    assign hex1 = hex_to_seg(data_q[7:4]);
    assign hex2 = hex_to_seg(data_q[11:8]);
    assign hex3 = hex_to_seg(data_q[15:12]);
    assign hex4 = hex_to_seg(data_q[19:16]);
    assign hex5 = hex_to_seg(data_q[23:20]);
    assign hex6 = hex_to_seg(data_q[27:24]);
    assign hex7 = hex_to_seg(data_q[31:28]);

endmodule

// File: tb/tb_register_display_scanner.sv
// tb/tb_register_display_scanner.sv - self-checking bench for register_display_scanner
module tb_register_display_scanner;

    localparam int D = 4;
    localparam int A = 10;

    logic clk, rst_n, btn_next, btn_prev, sw_auto;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [63:0] dut_hex;
    logic        ovr_en;
    logic [31:0] ovr_val;

    register_display_scanner_if rf_bus();

    register_display_scanner #(.DEBOUNCE_CYCLES(D), .AUTO_CYCLES(A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .sw_auto  (sw_auto),
        .rf       (rf_bus),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .hex6     (hex6),
        .hex7     (hex7)
    );

    function automatic logic [31:0] rf_val(input int idx);
        return ovr_en ? ovr_val : 32'(idx) * 32'h1111_1111;
    endfunction

    assign rf_bus.displayData = rf_val(int'(rf_bus.displaySelect));
    assign dut_hex = {1'b0, hex7, 1'b0, hex6, 1'b0, hex5, 1'b0, hex4,
                      1'b0, hex3, 1'b0, hex2, 1'b0, hex1, 1'b0, hex0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
              8'h00, 8'h10, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};
        return t[n];
    endfunction

    function automatic logic [63:0] exp_hex(input logic [31:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = seg_of(d[4*i +: 4]);
        return r;
    endfunction

    // Reference model: raw sample histories (bit k = sample k+1 edges ago),
    // level flips when the D synchronized samples preceding it all disagree.
    logic [D:0]  hn, hp, hs;
    int          m_idx, m_tmr;
    bit          ln, lp, pn, pp;
    logic [31:0] m_data;

    function automatic bit qualifies(input logic [D:0] h, input bit lvl);
        return lvl ? (h[D:1] == '0) : (&h[D:1]);
    endfunction

    task automatic model_reset();
        hn = '0; hp = '0; hs = '0;
        m_idx = 0; m_tmr = 0;
        ln = 0; lp = 0; pn = 0; pp = 0;
        m_data = '0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_data = rf_val(m_idx);
        if (pn || pp) begin
            m_tmr = 0;
            if (pn && !pp) m_idx = (m_idx + 1) % 32;
            if (pp && !pn) m_idx = (m_idx + 31) % 32;
        end else if (!hs[1]) begin
            m_tmr = 0;
        end else if (m_tmr == A - 1) begin
            m_tmr = 0;
            m_idx = (m_idx + 1) % 32;
        end else begin
            m_tmr++;
        end
        pn = 0; pp = 0;
        if (qualifies(hn, ln)) begin ln = !ln; pn = ln; end
        if (qualifies(hp, lp)) begin lp = !lp; pp = lp; end
        hn = {hn[D-1:0], btn_next};
        hp = {hp[D-1:0], btn_prev};
        hs = {hs[D-1:0], sw_auto};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("sel", 64'(rf_bus.displaySelect), 64'(m_idx));
        chk("hex", dut_hex, exp_hex(m_data));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_sel", 64'(rf_bus.displaySelect), 64'd0);
        chk("reset_hex", dut_hex, 64'h4040_4040_4040_4040);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic press(input logic n, input logic p);
        btn_next = n;
        btn_prev = p;
        repeat (8) tick();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (8) tick();
    endtask

    typedef struct {
        logic [31:0] data;
        logic [63:0] segs;
    } vec_t;

    vec_t vecs [4];
    int   waited, hold_n, hold_p;
    bit   tied;

    initial begin
        vecs[0] = '{32'h0123_ABCF, 64'h40_79_24_30_08_03_46_0E};
        vecs[1] = '{32'h4567_89DE, 64'h19_12_02_78_00_10_21_06};
        vecs[2] = '{32'hFEDC_BA98, 64'h0E_06_21_46_03_08_10_00};
        vecs[3] = '{32'h0000_0000, 64'h40_40_40_40_40_40_40_40};

        rst_n = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; sw_auto = 1'b0;
        ovr_en = 1'b0; ovr_val = '0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Bounce: 3 high / 1 low x5, then a steady hold
        for (int r = 0; r < 5; r++) begin
            btn_next = 1'b1; repeat (3) tick();
            btn_next = 1'b0; tick();
        end
        btn_next = 1'b1; repeat (10) tick();
        btn_next = 1'b0; repeat (10) tick();
        chk("bounce_idx", 64'(rf_bus.displaySelect), 64'd1);
        chk("bounce_hex", dut_hex, 64'h7979_7979_7979_7979);

        // Wrap both directions, then simultaneous presses
        press(1'b0, 1'b1);
        chk("prev_to_0", 64'(rf_bus.displaySelect), 64'd0);
        press(1'b0, 1'b1);
        chk("wrap_down", 64'(rf_bus.displaySelect), 64'd31);
        press(1'b1, 1'b0);
        chk("wrap_up", 64'(rf_bus.displaySelect), 64'd0);
        press(1'b1, 1'b1);
        chk("both_pressed", 64'(rf_bus.displaySelect), 64'd0);

        // Auto stepping from idx 5
        repeat (5) press(1'b1, 1'b0);
        chk("idx5", 64'(rf_bus.displaySelect), 64'd5);
        sw_auto = 1'b1;
        for (int s = 6; s <= 8; s++) begin
            waited = 0;
            while (rf_bus.displaySelect == 5'(s - 1) && waited < 40) begin
                tick();
                waited++;
            end
            chk("auto_idx", 64'(rf_bus.displaySelect), 64'(s));
            if (s > 6) chk("auto_interval", 64'(waited), 64'd10);
        end

        // Land a prev pulse exactly on the auto tick
        waited = 0;
        while (m_tmr != 3 && waited < 20) begin tick(); waited++; end
        btn_prev = 1'b1;
        waited = 0;
        while (rf_bus.displaySelect == 5'd8 && waited < 20) begin tick(); waited++; end
        chk("collide_dec", 64'(rf_bus.displaySelect), 64'd7);
        btn_prev = 1'b0;
        waited = 0;
        while (rf_bus.displaySelect == 5'd7 && waited < 40) begin tick(); waited++; end
        chk("collide_interval", 64'(waited), 64'd10);
        chk("collide_next", 64'(rf_bus.displaySelect), 64'd8);
        sw_auto = 1'b0;
        repeat (6) tick();

        // Button held through reset is re-qualified and steps once
        btn_next = 1'b1;
        repeat (8) tick();
        do_reset();
        repeat (12) tick();
        chk("held_reset_step", 64'(rf_bus.displaySelect), 64'd1);
        btn_next = 1'b0;
        repeat (10) tick();
        chk("held_reset_once", 64'(rf_bus.displaySelect), 64'd1);

        // Decode table
        ovr_en = 1'b1;
        for (int v = 0; v < 4; v++) begin
            ovr_val = vecs[v].data;
            tick();
            tick();
            chk("decode", dut_hex, vecs[v].segs);
        end
        ovr_en = 1'b0;
        tick();

        // Random stimulus against the model
        hold_n = 0; hold_p = 0; tied = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hold_n == 0) begin
                btn_next = 1'($urandom_range(0, 1));
                hold_n = $urandom_range(1, 9);
            end
            hold_n--;
            if (tied) begin
                btn_prev = btn_next;
            end else begin
                if (hold_p == 0) begin
                    btn_prev = 1'($urandom_range(0, 1));
                    hold_p = $urandom_range(1, 9);
                end
                hold_p--;
            end
            if ($urandom_range(0, 149) == 0) tied = !tied;
            if ($urandom_range(0, 59) == 0) sw_auto = !sw_auto;
            if ($urandom_range(0, 799) == 0) do_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
